// File: rtl/mult_div_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request/result bundle between the multicycle control unit
//                and the iterative multiply/divide unit. The master side
//                issues operations and MTHI/MTLO writes; the slave side
//                returns status and the architectural HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Requester: control unit (or testbench)
    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    // Responder: the arithmetic unit
    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative multiply/divide unit with architectural HI/LO.
//                MULT/MULTU use a shift-add loop, DIV/DIVU a restoring
//                divider, each WIDTH steps followed by one fix-up cycle.
//                Signed handling (sign-magnitude in, sign correction in the
//                fix-up cycle) is built only when MULTDIV_SIGNED_EN is
//                defined; otherwise op[0] is ignored and all ops are unsigned.
//  Config      : `define MULTDIV_SIGNED_EN to enable signed MULT/DIV.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic        clock,
    input  wire logic        reset,
    mult_div_unit_if.slave   bus
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_op_div;     // operation in flight is a divide
    logic [c_CNT_W-1:0]   r_count;      // remaining iteration steps
    logic [WIDTH-1:0]     r_opb;        // multiplicand / divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;        // {upper, lower}: product or {rem, quot}
    logic                 r_done;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_zero_div;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH-1:0]     w_trial;
    logic                 w_fits;
    logic [2*WIDTH-1:0]   w_div_nxt;

    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    // A request is only seen in IDLE; a zero divisor terminates it at once
    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_zero_div = bus.op[1] && (bus.b == '0);

`ifdef MULTDIV_SIGNED_EN
    logic w_sgn_op;
    logic w_sign_a;
    logic w_sign_b;
    logic r_neg_res;                    // negate product / quotient in FIX
    logic r_neg_rem;                    // negate remainder in FIX

    assign w_sgn_op = ~bus.op[0];
    assign w_sign_a = w_sgn_op & bus.a[WIDTH-1];
    assign w_sign_b = w_sgn_op & bus.b[WIDTH-1];
    // MIN maps to itself, which is the correct unsigned magnitude 2^(WIDTH-1)
    assign w_mag_a  = w_sign_a ? -bus.a : bus.a;
    assign w_mag_b  = w_sign_b ? -bus.b : bus.b;
`else
    assign w_mag_a  = bus.a;
    assign w_mag_b  = bus.b;
`endif

    // One iteration step for each algorithm, evaluated from the accumulator
    always_comb begin
        // Shift-add: add multiplicand to the upper half when the current
        // multiplier bit (acc LSB) is set, then shift the whole thing right.
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Restoring divide: shift next dividend bit into the remainder, and
        // subtract the divisor if it fits. Remainder < divisor before the
        // shift, so the difference always fits back into WIDTH bits.
        w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_fits    = (w_rem_sh >= {1'b0, r_opb});
        w_trial   = w_rem_sh[WIDTH-1:0] - r_opb;
        w_div_nxt = {(w_fits ? w_trial : w_rem_sh[WIDTH-1:0]),
                     r_acc[WIDTH-2:0], w_fits};
    end

    // Final result with sign correction applied (FIX cycle)
    always_comb begin
        w_prod = r_acc;
        w_quot = r_acc[WIDTH-1:0];
        w_rem  = r_acc[2*WIDTH-1:WIDTH];
`ifdef MULTDIV_SIGNED_EN
        if (r_neg_res) begin
            w_prod = -r_acc;
            w_quot = -r_acc[WIDTH-1:0];
        end
        if (r_neg_rem) begin
            w_rem  = -r_acc[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !w_zero_div) begin
                    w_state_nxt = bus.op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (r_count == c_CNT_ONE) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_DIV: begin
                if (r_count == c_CNT_ONE) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath, counter and status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op_div  <= 1'b0;
            r_count   <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Both algorithms start from {0, |a|} with |b| aside
                        r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
                        r_opb     <= w_mag_b;
                        r_count   <= c_CNT_INIT;
                        r_op_div  <= bus.op[1];
                        r_dbz     <= w_zero_div;
                        r_done    <= w_zero_div;
`ifdef MULTDIV_SIGNED_EN
                        r_neg_res <= w_sign_a ^ w_sign_b;
                        r_neg_rem <= w_sign_a;
`endif
                    end
                end
                S_MUL: begin
                    r_acc   <= w_mul_nxt;
                    r_count <= r_count - c_CNT_ONE;
                end
                S_DIV: begin
                    r_acc   <= w_div_nxt;
                    r_count <= r_count - c_CNT_ONE;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    // Architectural HI/LO: result write in FIX, MTHI/MTLO only while idle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX) begin
            if (r_op_div) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end else begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end
        end else if (r_state == S_IDLE) begin
            if (bus.hi_we) begin
                r_hi <= bus.wdata;
            end
            if (bus.lo_we) begin
                r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire
